// File: rtl/bit_seq_recorder.sv
// bit_seq_recorder
// Front end of the bit-sequence display path. Four raw push-buttons are
// synchronised and debounced into single-cycle press events. A small FSM turns
// those events into a recorded sequence of up to 16 bits for the playback stage.
//
// Handshake toward playback: 'ready' is a level, not a pulse. While ready=1,
// data, count and last_idx are frozen. They stay frozen until a clear press
// returns the recorder to IDLE. Playback may sample them on any cycle in which
// ready=1.

module bit_seq_recorder #(
    parameter int DEB_CYC = 50000,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn0,
    input  logic        btn1,
    input  logic        btn_done,
    input  logic        btn_clr,
    output logic [15:0] data,
    output logic [3:0]  last_idx,
    output logic [4:0]  count,
    output logic        full,
    output logic        ready,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RECORD = 2'b01,
        S_DONE   = 2'b10
    } state_t;

    // Terminal count of a debounce counter: the level flips on this cycle.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

    // Button lanes, bit order: 0 = btn0, 1 = btn1, 2 = btn_done, 3 = btn_clr.
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       press;
    logic [CNT_W-1:0] deb_cnt [4];

    logic p0;
    logic p1;
    logic p_done;
    logic p_clr;
    logic bit_evt;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic [4:0]  count_q;
    logic [4:0]  count_d;
    logic [4:0]  count_w;
    logic [3:0]  last_q;
    logic [3:0]  last_d;

    assign raw = {btn_clr, btn_done, btn1, btn0};

    // Two-flop synchroniser on every raw button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a lane's level follows the synchronised input only after the
    // input has disagreed with it for DEB_CYC consecutive cycles. A rising flip
    // also emits a one-cycle press pulse. Releases never produce an event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= 4'b0;
            press <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    press[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign p0      = press[0];
    assign p1      = press[1];
    assign p_done  = press[2];
    assign p_clr   = press[3];
    // Two bit buttons landing in the same cycle are ambiguous, so neither counts.
    assign bit_evt = p0 ^ p1;

    // Recorder state and sequence registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= 16'h0000;
            count_q <= 5'd0;
            last_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic. A clear press takes priority over every other event.
    // A done press in the same cycle as a bit press sees the bit already
    // appended (count_w), so last_idx points at the bit just written.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        count_w = count_q;
        case (state_q)
            S_IDLE: begin
                data_d  = 16'h0000;
                count_d = 5'd0;
                if (en) begin
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                if (p_clr || !en) begin
                    state_d = S_IDLE;
                    data_d  = 16'h0000;
                    count_d = 5'd0;
                end else begin
                    if (bit_evt && !count_q[4]) begin
                        data_d[count_q[3:0]] = p1;
                        count_w              = count_q + 5'd1;
                    end
                    count_d = count_w;
                    if (p_done && (count_w != 5'd0)) begin
                        state_d = S_DONE;
                        last_d  = 4'(count_w - 5'd1);
                    end
                end
            end
            S_DONE: begin
                // Leaving the enable does not drop a finished sequence, so
                // playback survives a mode switch.
                if (p_clr) begin
                    state_d = S_IDLE;
                    data_d  = 16'h0000;
                    count_d = 5'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data     = data_q;
    assign count    = count_q;
    assign last_idx = last_q;
    assign full     = count_q[4];
    assign ready    = (state_q == S_DONE);
    assign state    = state_q;

endmodule

// File: tb/tb_bit_seq_recorder.sv
// Testbench for bit_seq_recorder, run with DEB_CYC = 4.
// A reference model tracks debounced presses and the recorded bit list. It is
// compared with the DUT on every cycle. Table vectors and hand-written
// sequences add fixed expected values on top of that.

module tb_bit_seq_recorder;

    localparam int DEB  = 4;
    localparam int HOLD = DEB + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        btn0;
    logic        btn1;
    logic        btn_done;
    logic        btn_clr;
    logic [15:0] data;
    logic [3:0]  last_idx;
    logic [4:0]  count;
    logic        full;
    logic        ready;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bit_seq_recorder #(.DEB_CYC(DEB), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn0     (btn0),
        .btn1     (btn1),
        .btn_done (btn_done),
        .btn_clr  (btn_clr),
        .data     (data),
        .last_idx (last_idx),
        .count    (count),
        .full     (full),
        .ready    (ready),
        .state    (state)
    );

    // ---------------- reference model ----------------
    // A synced level becomes the debounced level once the last DEB synced
    // samples all disagree with the current debounced level.
    bit           m_s1 [4];
    bit           m_s2 [4];
    bit           m_deb [4];
    bit           m_press [4];
    logic [DEB-1:0] m_hist [4];
    int           m_fill [4];
    bit           m_bits [$];
    int           m_mode;   // 0 idle, 1 recording, 2 done
    int           m_last;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_s1[b]    = 1'b0;
            m_s2[b]    = 1'b0;
            m_deb[b]   = 1'b0;
            m_press[b] = 1'b0;
            m_hist[b]  = '0;
            m_fill[b]  = 0;
        end
        m_bits.delete();
        m_mode = 0;
        m_last = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        bit p [4];
        if (!rst) begin
            model_reset();
            return;
        end
        raw = {btn_clr, btn_done, btn1, btn0};
        for (int b = 0; b < 4; b++) p[b] = m_press[b];
        case (m_mode)
            0: begin
                m_bits.delete();
                if (en) m_mode = 1;
            end
            1: begin
                if (p[3] || !en) begin
                    m_mode = 0;
                    m_bits.delete();
                end else begin
                    if ((p[0] != p[1]) && (m_bits.size() < 16)) m_bits.push_back(p[1]);
                    if (p[2] && (m_bits.size() > 0)) begin
                        m_mode = 2;
                        m_last = m_bits.size() - 1;
                    end
                end
            end
            default: begin
                if (p[3]) begin
                    m_mode = 0;
                    m_bits.delete();
                end
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            m_press[b] = 1'b0;
            m_hist[b]  = {m_hist[b][DEB-2:0], m_s2[b]};
            if (m_fill[b] < DEB) m_fill[b]++;
            if ((m_fill[b] == DEB) && (m_hist[b] == {DEB{~m_deb[b]}})) begin
                m_deb[b]   = m_s2[b];
                m_press[b] = m_s2[b];
                m_fill[b]  = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [15:0] d;
        d = 16'h0000;
        for (int k = 0; k < m_bits.size(); k++) d[k] = m_bits[k];
        check("model", {data, count, full, ready, state, last_idx},
              {d, 5'(m_bits.size()), (m_bits.size() == 16), (m_mode == 2), 2'(m_mode), 4'(m_last)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data,     16'h0000);
        check({tag, "_last"},  last_idx, 4'd0);
        check({tag, "_count"}, count,    5'd0);
        check({tag, "_full"},  full,     1'b0);
        check({tag, "_ready"}, ready,    1'b0);
        check({tag, "_state"}, state,    2'b00);
    endtask

    // ---------------- driver ----------------
    // One clock: the model follows the edge, and the outputs are compared on
    // the falling edge. Callers change inputs after tick returns.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic press_mask(input logic [3:0] m);
        {btn_clr, btn_done, btn1, btn0} = m;
        repeat (HOLD) tick();
        {btn_clr, btn_done, btn1, btn0} = 4'b0000;
        repeat (HOLD) tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst = 1'b1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          btn;    // 0 btn0, 1 btn1, 2 done, 3 clr, 4 none
        logic        en;
        logic [15:0] data;
        logic [4:0]  count;
        logic        ready;
        logic [1:0]  state;
        logic [3:0]  last;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          hold [4];
        int          en_hold;
        int          base;
        logic [15:0] exp_d;

        vecs[0]  = '{1, 1'b1, 16'h0001, 5'd1, 1'b0, 2'b01, 4'd0};
        vecs[1]  = '{0, 1'b1, 16'h0001, 5'd2, 1'b0, 2'b01, 4'd0};
        vecs[2]  = '{1, 1'b1, 16'h0005, 5'd3, 1'b0, 2'b01, 4'd0};
        vecs[3]  = '{1, 1'b1, 16'h000D, 5'd4, 1'b0, 2'b01, 4'd0};
        vecs[4]  = '{2, 1'b1, 16'h000D, 5'd4, 1'b1, 2'b10, 4'd3};
        vecs[5]  = '{1, 1'b1, 16'h000D, 5'd4, 1'b1, 2'b10, 4'd3};
        vecs[6]  = '{4, 1'b0, 16'h000D, 5'd4, 1'b1, 2'b10, 4'd3};
        vecs[7]  = '{3, 1'b0, 16'h0000, 5'd0, 1'b0, 2'b00, 4'd3};
        vecs[8]  = '{4, 1'b1, 16'h0000, 5'd0, 1'b0, 2'b01, 4'd3};
        vecs[9]  = '{2, 1'b1, 16'h0000, 5'd0, 1'b0, 2'b01, 4'd3};
        vecs[10] = '{0, 1'b1, 16'h0000, 5'd1, 1'b0, 2'b01, 4'd3};
        vecs[11] = '{1, 1'b1, 16'h0002, 5'd2, 1'b0, 2'b01, 4'd3};
        vecs[12] = '{4, 1'b0, 16'h0000, 5'd0, 1'b0, 2'b00, 4'd3};

        // reset
        rst = 1'b0; en = 1'b0;
        btn0 = 1'b0; btn1 = 1'b0; btn_done = 1'b0; btn_clr = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;

        // table vectors
        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en;
            if (vecs[i].btn < 4) press_mask(4'(1 << vecs[i].btn));
            else repeat (2 * HOLD) tick();
            check($sformatf("vec%0d_data", i),  data,     vecs[i].data);
            check($sformatf("vec%0d_count", i), count,    vecs[i].count);
            check($sformatf("vec%0d_full", i),  full,     (vecs[i].count == 5'd16));
            check($sformatf("vec%0d_ready", i), ready,    vecs[i].ready);
            check($sformatf("vec%0d_state", i), state,    vecs[i].state);
            check($sformatf("vec%0d_last", i),  last_idx, vecs[i].last);
        end

        // press latency: write lands 2+DEB+1 edges after the raw edge
        en = 1'b1;
        repeat (2) tick();
        base = m_bits.size();
        btn1 = 1'b1;
        repeat (2 + DEB) tick();
        check("latency_early", count, 5'(base));
        tick();
        check("latency_edge", count, 5'(base + 1));
        btn1 = 1'b0;
        repeat (HOLD) tick();

        // bounce: 2-cycle toggles never outlast the filter
        base = m_bits.size();
        for (int i = 0; i < 10; i++) begin
            btn1 = ~btn1;
            tick();
            tick();
            check("bounce_hold", count, 5'(base));
        end
        btn1 = 1'b1;
        repeat (HOLD) tick();
        check("bounce_count", count, 5'(base + 1));
        check("bounce_bit", data[base], 1'b1);
        btn1 = 1'b0;
        repeat (HOLD) tick();

        // fill to 16 and beyond
        press_mask(4'b1000);
        check("fill_start", count, 5'd0);
        for (int i = 0; i < 18; i++) begin
            press_mask(4'b0010);
            if (i == 15) check("fill_full16", full, 1'b1);
        end
        check("fill_count", count, 5'd16);
        check("fill_data", data, 16'hFFFF);
        check("fill_full", full, 1'b1);
        press_mask(4'b0100);
        check("fill_last", last_idx, 4'd15);
        check("fill_ready", ready, 1'b1);

        // simultaneous bit presses, then done at zero count
        press_mask(4'b1000);
        press_mask(4'b0011);
        check("both_count", count, 5'd0);
        press_mask(4'b0100);
        check("done0_state", state, 2'b01);
        check("done0_ready", ready, 1'b0);
        press_mask(4'b0001);
        press_mask(4'b0011);
        check("both_count1", count, 5'd1);

        // bit press and done together: bit first, then close
        press_mask(4'b0110);
        check("bitdone_state", state, 2'b10);
        check("bitdone_last", last_idx, 4'd1);
        check("bitdone_data", data, 16'h0002);
        press_mask(4'b1000);

        // reset mid-record at count 5
        for (int i = 0; i < 5; i++) press_mask(4'(1 << (i % 2)));
        check("pre_rst_count", count, 5'd5);
        reset_pulse();
        tick();

        // randomised traffic against the model
        for (int b = 0; b < 4; b++) hold[b] = 0;
        en_hold = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    case (b)
                        0: btn0     = 1'($urandom_range(0, 1));
                        1: btn1     = 1'($urandom_range(0, 1));
                        2: btn_done = ($urandom_range(0, 5) == 0);
                        default: btn_clr = ($urandom_range(0, 15) == 0);
                    endcase
                    hold[b] = $urandom_range(1, 12);
                end else begin
                    hold[b]--;
                end
            end
            if (en_hold == 0) begin
                en      = ($urandom_range(0, 7) != 0);
                en_hold = $urandom_range(5, 60);
            end else begin
                en_hold--;
            end
            if ($urandom_range(0, 699) == 0) reset_pulse();
            else tick();
        end

        // final sanity against a fixed expectation built from the model list
        exp_d = 16'h0000;
        for (int k = 0; k < m_bits.size(); k++) exp_d[k] = m_bits[k];
        check("final_data", data, exp_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
